aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 71 +++++++
 rtl/aes32dsmi.sv | 41 ++++
 rtl/aes32esi.sv | 31 +++
 rtl/aes_key_expand.sv | 218 +++++++++++++++++++++
 tb/tb_aes_key_expand.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round constants, buffer sizing,
// controller state type and the GF(2^8) / S-box helpers used by the
// round-instruction sub-modules.
package aes_pkg;

    localparam int NUM_RK_WORDS = 44;
    localparam int NUM_ROUNDS   = 10;
    localparam int INV_FIRST    = 4;
    localparam int INV_LAST     = 39;

    // Round constants, top byte of the word; index is the round number.
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SUB  = 3'd2,
        GEN  = 3'd3,
        INV  = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] rol_byte(input logic [7:0] a, input int k);
        return (a << k) | (a >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rol_byte(v, 1) ^ rol_byte(v, 2) ^ rol_byte(v, 3) ^ rol_byte(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv(rol_byte(a, 1) ^ rol_byte(a, 3) ^ rol_byte(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes32dsmi.sv
// Middle-round decrypt byte step: inverse S-box one byte of rs2, expand it
// into its InvMixColumns column contribution (row 0 in the low byte) rotated
// to lane bs, and xor into rs1.
module aes32dsmi
    import aes_pkg::*;
(
    input  logic [1:0]  bs,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);

    logic [7:0]  si;
    logic [7:0]  so;
    logic [31:0] mixed;
    logic [31:0] rot;

    // Inverse substitute, multiply by the InvMixColumns column, rotate into lane.
    always_comb begin
        si = 8'h00;
        case (bs)
            2'd0: si = rs2[7:0];
            2'd1: si = rs2[15:8];
            2'd2: si = rs2[23:16];
            2'd3: si = rs2[31:24];
            default: si = 8'h00;
        endcase
        so    = sbox_inv(si);
        mixed = {gf_mul(so, 8'h0b), gf_mul(so, 8'h0d), gf_mul(so, 8'h09), gf_mul(so, 8'h0e)};
        rot   = mixed;
        case (bs)
            2'd0: rot = mixed;
            2'd1: rot = {mixed[23:0], mixed[31:24]};
            2'd2: rot = {mixed[15:0], mixed[31:16]};
            2'd3: rot = {mixed[7:0],  mixed[31:8]};
            default: rot = mixed;
        endcase
        rd = rs1 ^ rot;
    end

endmodule

// File: rtl/aes32esi.sv
// Final-round encrypt byte step: S-box one byte of rs2 selected by bs and
// xor it back into the same byte lane of rs1.
module aes32esi
    import aes_pkg::*;
(
    input  logic [1:0]  bs,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);

    logic [7:0]  si;
    logic [7:0]  so;
    logic [31:0] lane;

    // Byte select, substitute, and place back in its own lane.
    always_comb begin
        si = 8'h00;
        case (bs)
            2'd0: si = rs2[7:0];
            2'd1: si = rs2[15:8];
            2'd2: si = rs2[23:16];
            2'd3: si = rs2[31:24];
            default: si = 8'h00;
        endcase
        so   = sbox_fwd(si);
        lane = {24'h000000, so} << {bs, 3'b000};
        rd   = rs1 ^ lane;
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion into a 44-word round-key buffer, optionally
// followed by conversion of words 4..39 to equivalent-inverse-cipher keys.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; buffer readable
// LOAD  | copy captured cipher key into words 0..3, r = 1
// SUB   | 4 aes32esi steps: RCON[r] ^ SubWord(RotWord(w[4r-1])) -> temp
// GEN   | write w[4r..4r+3]; next round, INV or DONE
// INV   | per word 4..39: 4 esi steps (SubWord) then 4 dsmi steps
// DONE  | one-cycle done pulse, key set valid
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dec_i,
    input  logic [127:0] key_i,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic [5:0]   rk_rd_idx,
    output logic [31:0]  rk_rd_data
);

    state_t       state;
    logic [3:0]   r;
    logic [1:0]   bs;
    logic [31:0]  temp;
    logic         dec_q;
    logic [5:0]   inv_idx;
    logic         inv_ph;
    logic [31:0]  inv_acc;
    logic [127:0] key_q;

    logic [31:0]  rk_buf [NUM_RK_WORDS];

    logic [5:0]   base;
    logic [31:0]  esi_rs1, esi_rs2, esi_rd;
    logic [31:0]  dsmi_rs1, dsmi_rs2, dsmi_rd;
    logic [31:0]  prev_w;
    logic [31:0]  gen_w [4];

    logic         wr_en  [4];
    logic [5:0]   wr_idx [4];
    logic [31:0]  wr_dat [4];

    assign base = {r, 2'b00};

    aes32esi u_esi (
        .bs  (bs),
        .rs1 (esi_rs1),
        .rs2 (esi_rs2),
        .rd  (esi_rd)
    );

    aes32dsmi u_dsmi (
        .bs  (bs),
        .rs1 (dsmi_rs1),
        .rs2 (dsmi_rs2),
        .rd  (dsmi_rd)
    );

    // Operand steering for the two round-instruction units.
    // The dsmi unit treats the low byte as row 0 while key words keep row 0
    // in the top byte, so its operand and result are byte-swapped around it.
    always_comb begin
        esi_rs1  = 32'h0;
        esi_rs2  = 32'h0;
        dsmi_rs1 = 32'h0;
        dsmi_rs2 = 32'h0;
        prev_w   = rk_buf[base - 6'd1];
        case (state)
            SUB: begin
                esi_rs1 = (bs == 2'd0) ? {RCON[r], 24'h000000} : temp;
                esi_rs2 = {prev_w[23:0], prev_w[31:24]};
            end
            INV: begin
                esi_rs1  = (bs == 2'd0) ? 32'h0 : temp;
                esi_rs2  = rk_buf[inv_idx];
                dsmi_rs1 = (bs == 2'd0) ? 32'h0 : inv_acc;
                dsmi_rs2 = {temp[7:0], temp[15:8], temp[23:16], temp[31:24]};
            end
            default: ;
        endcase
    end

    // Next four schedule words for the current round.
    always_comb begin
        gen_w[0] = rk_buf[base - 6'd4] ^ temp;
        gen_w[1] = rk_buf[base - 6'd3] ^ gen_w[0];
        gen_w[2] = rk_buf[base - 6'd2] ^ gen_w[1];
        gen_w[3] = rk_buf[base - 6'd1] ^ gen_w[2];
    end

    // Buffer write ports: LOAD and GEN use all four, INV uses port 0.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            wr_en[p]  = 1'b0;
            wr_idx[p] = 6'd0;
            wr_dat[p] = 32'h0;
        end
        case (state)
            LOAD: begin
                for (int p = 0; p < 4; p++) begin
                    wr_en[p]  = 1'b1;
                    wr_idx[p] = 6'(p);
                    wr_dat[p] = key_q[127 - 32*p -: 32];
                end
            end
            GEN: begin
                for (int p = 0; p < 4; p++) begin
                    wr_en[p]  = 1'b1;
                    wr_idx[p] = base + 6'(p);
                    wr_dat[p] = gen_w[p];
                end
            end
            INV: begin
                if (inv_ph && bs == 2'd3) begin
                    wr_en[0]  = 1'b1;
                    wr_idx[0] = inv_idx;
                    wr_dat[0] = {dsmi_rd[7:0], dsmi_rd[15:8], dsmi_rd[23:16], dsmi_rd[31:24]};
                end
            end
            default: ;
        endcase
    end

    // Key capture and round-key storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) key_q <= key_i;
        for (int p = 0; p < 4; p++) begin
            if (wr_en[p]) rk_buf[wr_idx[p]] <= wr_dat[p];
        end
    end

    // Sequencer with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
            r        <= 4'd0;
            bs       <= 2'd0;
            temp     <= 32'h0;
            dec_q    <= 1'b0;
            inv_idx  <= 6'd0;
            inv_ph   <= 1'b0;
            inv_acc  <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        rk_valid <= 1'b0;
                        dec_q    <= dec_i;
                    end
                end
                LOAD: begin
                    state <= SUB;
                    r     <= 4'd1;
                    bs    <= 2'd0;
                end
                SUB: begin
                    temp <= esi_rd;
                    bs   <= bs + 2'd1;
                    if (bs == 2'd3) state <= GEN;
                end
                GEN: begin
                    if (r < 4'(NUM_ROUNDS)) begin
                        r     <= r + 4'd1;
                        state <= SUB;
                    end else if (dec_q) begin
                        state   <= INV;
                        inv_idx <= 6'(INV_FIRST);
                        inv_ph  <= 1'b0;
                        bs      <= 2'd0;
                    end else begin
                        state    <= DONE;
                        done     <= 1'b1;
                        rk_valid <= 1'b1;
                    end
                end
                INV: begin
                    bs <= bs + 2'd1;
                    if (!inv_ph) begin
                        temp <= esi_rd;
                        if (bs == 2'd3) inv_ph <= 1'b1;
                    end else begin
                        inv_acc <= dsmi_rd;
                        if (bs == 2'd3) begin
                            inv_ph <= 1'b0;
                            if (inv_idx == 6'(INV_LAST)) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                rk_valid <= 1'b1;
                            end else begin
                                inv_idx <= inv_idx + 6'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rk_rd_data = (rk_rd_idx < 6'(NUM_RK_WORDS)) ? rk_buf[rk_rd_idx] : 32'h0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed plus randomized bench for aes_key_expand against a FIPS-197
// style key-schedule model built from a literal S-box table.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dec_i;
    logic [127:0] key_i;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [5:0]   rk_rd_idx;
    logic [31:0]  rk_rd_data;

    int n_vec = 0;
    int n_err = 0;

    logic [2047:0] sbox_tab;
    logic [31:0]   exp_w [44];

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dec_i      (dec_i),
        .key_i      (key_i),
        .busy       (busy),
        .done       (done),
        .rk_valid   (rk_valid),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] a);
        return sbox_tab[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {mul(a0,8'h0e) ^ mul(a1,8'h0b) ^ mul(a2,8'h0d) ^ mul(a3,8'h09),
                mul(a0,8'h09) ^ mul(a1,8'h0e) ^ mul(a2,8'h0b) ^ mul(a3,8'h0d),
                mul(a0,8'h0d) ^ mul(a1,8'h09) ^ mul(a2,8'h0e) ^ mul(a3,8'h0b),
                mul(a0,8'h0b) ^ mul(a1,8'h0d) ^ mul(a2,8'h09) ^ mul(a3,8'h0e)};
    endfunction

    // Textbook key schedule, then InvMixColumns over words 4..39 when dec.
    task automatic model_expand(input logic [127:0] key, input logic dec);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) exp_w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = exp_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            exp_w[i] = exp_w[i-4] ^ t;
        end
        if (dec) for (int i = 4; i < 40; i++) exp_w[i] = inv_mix(exp_w[i]);
    endtask

    task automatic read_word(input int idx, output logic [31:0] d);
        rk_rd_idx = 6'(idx);
        #1;
        d = rk_rd_data;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 44; i++) begin
            read_word(i, d);
            check($sformatf("%s_w%0d", tag, i), d, exp_w[i]);
        end
    endtask

    task automatic check_const(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        read_word(idx, d);
        check(tag, d, exp);
    endtask

    // Drives start at a negedge; cycle k is the k-th negedge after edge T.
    task automatic run_expand(input logic [127:0] key, input logic dec, input int again_at,
                              input int abort_at, output int done_at, output int n_done);
        done_at = -1;
        n_done  = 0;
        key_i = key;
        dec_i = dec;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        key_i = {$urandom, $urandom, $urandom, $urandom};
        dec_i = ~dec;
        for (int k = 1; k <= 400; k++) begin
            if (k == again_at) start = 1'b1;
            if (k == again_at + 1) start = 1'b0;
            if (k == 1) check("busy_first_cycle", {31'b0, busy}, 32'd1);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_busy", {31'b0, busy}, 32'd0);
                check("abort_rk_valid", {31'b0, rk_valid}, 32'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (80) begin
                    @(negedge clk);
                    if (done) n_done++;
                end
                return;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
                check("busy_at_done", {31'b0, busy}, 32'd1);
            end
            if (done_at > 0 && k == done_at + 1)
                check("busy_after_done", {31'b0, busy}, 32'd0);
            if (done_at > 0 && k >= done_at + 4) break;
            @(negedge clk);
        end
        check("done_seen", {31'b0, (done_at >= 0 || abort_at != 0)}, 32'd1);
    endtask

    initial begin
        int          d_at;
        int          n_d;
        logic [127:0] key;
        logic        dec;
        logic [31:0] d;

        sbox_tab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

        rst = 1'b1; start = 1'b0; dec_i = 1'b0; key_i = '0; rk_rd_idx = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_rk_valid", {31'b0, rk_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario A
        run_expand(KEY_A, 1'b0, 0, 0, d_at, n_d);
        check("A_done_at", d_at, 32'd52);
        check("A_done_count", n_d, 32'd1);
        check("A_rk_valid", {31'b0, rk_valid}, 32'd1);
        check_const("A_w4", 4, 32'hd6aa74fd);
        check_const("A_w40", 40, 32'h13111d7f);
        check_const("A_w41", 41, 32'he3944a17);
        check_const("A_w42", 42, 32'hf307a78b);
        check_const("A_w43", 43, 32'h4d2b30c5);
        model_expand(KEY_A, 1'b0);
        check_all("A");

        // Scenario B
        run_expand(KEY_B, 1'b0, 0, 0, d_at, n_d);
        check("B_done_at", d_at, 32'd52);
        check_const("B_w4", 4, 32'ha0fafe17);
        check_const("B_w40", 40, 32'hd014f9a8);
        check_const("B_w41", 41, 32'hc9ee2589);
        check_const("B_w42", 42, 32'he13f0cc8);
        check_const("B_w43", 43, 32'hb6630ca6);
        model_expand(KEY_B, 1'b0);
        check_all("B");

        // Scenario C
        run_expand(KEY_A, 1'b1, 0, 0, d_at, n_d);
        check("C_done_at", d_at, 32'd340);
        check("C_done_count", n_d, 32'd1);
        check_const("C_w0", 0, 32'h00010203);
        check_const("C_w40", 40, 32'h13111d7f);
        check_const("C_w43", 43, 32'h4d2b30c5);
        model_expand(KEY_A, 1'b1);
        check_all("C");

        // Scenario D
        run_expand(KEY_A, 1'b0, 10, 0, d_at, n_d);
        check("D_done_at", d_at, 32'd52);
        check("D_done_count", n_d, 32'd1);
        repeat (60) begin
            @(negedge clk);
            if (done) n_d++;
        end
        check("D_no_extra_done", n_d, 32'd1);
        check("D_idle_busy", {31'b0, busy}, 32'd0);
        check_const("D_idx44", 44, 32'h0);
        check_const("D_idx63", 63, 32'h0);
        read_word(45 + ($urandom % 18), d);
        check("D_idx_rand_oob", d, 32'h0);

        // Scenario E
        run_expand(KEY_B, 1'b0, 0, 20, d_at, n_d);
        check("E_no_done", n_d, 32'd0);
        check("E_busy", {31'b0, busy}, 32'd0);
        check("E_rk_valid", {31'b0, rk_valid}, 32'd0);
        run_expand(KEY_A, 1'b0, 0, 0, d_at, n_d);
        check("E_restart_done_at", d_at, 32'd52);
        check("E_restart_rk_valid", {31'b0, rk_valid}, 32'd1);
        model_expand(KEY_A, 1'b0);
        check_all("E");

        // Random keys and modes
        for (int n = 0; n < 4; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom % 2);
            run_expand(key, dec, 0, 0, d_at, n_d);
            check($sformatf("R%0d_done_at", n), d_at, dec ? 32'd340 : 32'd52);
            check($sformatf("R%0d_done_count", n), n_d, 32'd1);
            model_expand(key, dec);
            check_all($sformatf("R%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
